// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with registered operands/results on a valid/ready
// handshake; single-cycle ADD/SUB/AND/OR/SLL/SRA plus iterative signed MUL and DIV.
module alu_multicycle #(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic [4:0]         ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow,
    output logic               exception
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    // Magnitude of a two's-complement value; MIN maps to unsigned 2^(WIDTH-1)
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v);
        mag_f = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_f(input logic [2*WIDTH-1:0] v);
        neg2_f = ~v + (2*WIDTH)'(1);
    endfunction

    state_t               state_r, state_next_s;
    logic                 in_ready_r, out_valid_r;
    logic [WIDTH-1:0]     result_r, result_next_s;
    logic                 ne_r, ne_next_s, lt_r, lt_next_s;
    logic                 ovf_r, ovf_next_s, exc_r, exc_next_s;
    // MUL: {partial product high, multiplier}; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   acc_r, acc_next_s;
    logic [WIDTH-1:0]     opnd_r, opnd_next_s;
    logic [SHAMT_W-1:0]   cnt_r, cnt_next_s;
    logic                 neg_r, neg_next_s, div_r, div_next_s;

    logic [WIDTH-1:0]     sum_s, diff_s, quo_s;
    logic [WIDTH:0]       mul_sum_s, div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0]   mul_step_s, div_step_s, prod_s;

    // One shift-add multiply step and one restoring divide step on the shared accumulator
    always_comb begin
        sum_s       = data_operandA + data_operandB;
        diff_s      = data_operandA - data_operandB;
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                    + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        mul_step_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (div_diff_s[WIDTH] == 1'b0) begin
            div_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_step_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
        quo_s  = div_step_s[WIDTH-1:0];
        prod_s = neg_r ? neg2_f(mul_step_s) : mul_step_s;
    end

    // Next-state and next-register logic for the IDLE/BUSY/DONE handshake FSM
    always_comb begin
        state_next_s  = state_r;
        result_next_s = result_r;
        ne_next_s     = ne_r;
        lt_next_s     = lt_r;
        ovf_next_s    = ovf_r;
        exc_next_s    = exc_r;
        acc_next_s    = acc_r;
        opnd_next_s   = opnd_r;
        cnt_next_s    = cnt_r;
        neg_next_s    = neg_r;
        div_next_s    = div_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    ne_next_s     = (data_operandA != data_operandB);
                    lt_next_s     = ($signed(data_operandA) < $signed(data_operandB));
                    neg_next_s    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    div_next_s    = (ctrl_ALUopcode == OP_DIV);
                    cnt_next_s    = {SHAMT_W{1'b0}};
                    result_next_s = {WIDTH{1'b0}};
                    ovf_next_s    = 1'b0;
                    exc_next_s    = 1'b0;
                    state_next_s  = ST_DONE;
                    case (ctrl_ALUopcode)
                        OP_ADD: begin
                            result_next_s = sum_s;
                            ovf_next_s    = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1])
                                         && (sum_s[WIDTH-1] != data_operandA[WIDTH-1]);
                        end
                        OP_SUB: begin
                            result_next_s = diff_s;
                            ovf_next_s    = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1])
                                         && (diff_s[WIDTH-1] != data_operandA[WIDTH-1]);
                        end
                        OP_AND: result_next_s = data_operandA & data_operandB;
                        OP_OR:  result_next_s = data_operandA | data_operandB;
                        OP_SLL: result_next_s = data_operandA << ctrl_shiftamt;
                        OP_SRA: result_next_s = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
                        OP_MUL: begin
                            opnd_next_s  = mag_f(data_operandA);
                            acc_next_s   = {{WIDTH{1'b0}}, mag_f(data_operandB)};
                            state_next_s = ST_BUSY;
                        end
                        OP_DIV: begin
                            if (data_operandB == {WIDTH{1'b0}}) begin
                                exc_next_s = 1'b1;
                            end else begin
                                opnd_next_s  = mag_f(data_operandB);
                                acc_next_s   = {{WIDTH{1'b0}}, mag_f(data_operandA)};
                                state_next_s = ST_BUSY;
                            end
                        end
                        default: exc_next_s = 1'b1;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                acc_next_s = div_r ? div_step_s : mul_step_s;
                cnt_next_s = cnt_r + SHAMT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                    cnt_next_s   = {SHAMT_W{1'b0}};
                    if (div_r) begin
                        // Only MIN / -1 yields a positive quotient of 2^(WIDTH-1)
                        result_next_s = neg_r ? (~quo_s + WIDTH'(1)) : quo_s;
                        ovf_next_s    = ~neg_r & quo_s[WIDTH-1];
                    end else begin
                        result_next_s = prod_s[WIDTH-1:0];
                        ovf_next_s    = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
                    end
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            ne_r        <= 1'b0;
            lt_r        <= 1'b0;
            ovf_r       <= 1'b0;
            exc_r       <= 1'b0;
            acc_r       <= {(2*WIDTH){1'b0}};
            opnd_r      <= {WIDTH{1'b0}};
            cnt_r       <= {SHAMT_W{1'b0}};
            neg_r       <= 1'b0;
            div_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
            result_r    <= result_next_s;
            ne_r        <= ne_next_s;
            lt_r        <= lt_next_s;
            ovf_r       <= ovf_next_s;
            exc_r       <= exc_next_s;
            acc_r       <= acc_next_s;
            opnd_r      <= opnd_next_s;
            cnt_r       <= cnt_next_s;
            neg_r       <= neg_next_s;
            div_r       <= div_next_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign data_result = result_r;
    assign isNotEqual  = ne_r;
    assign isLessThan  = lt_r;
    assign overflow    = ovf_r;
    assign exception   = exc_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed + scoreboard testbench for alu_multicycle at WIDTH=32.
module tb_alu_multicycle;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_ALUopcode;
    logic [4:0]  ctrl_shiftamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;
    logic        exception;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        exc;
        logic        ne;
        logic        lt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
        .out_valid(out_valid), .out_ready(out_ready), .data_result(data_result),
        .isNotEqual(isNotEqual), .isLessThan(isLessThan),
        .overflow(overflow), .exception(exception)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_v(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic o, input logic e,
                                input logic n, input logic l);
        mk = {r, o, e, n, l};
    endfunction

    // Reference model built on the simulator's own 64-bit signed arithmetic
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] op, input logic [4:0] sh);
        logic signed [63:0] p;
        logic [31:0] r;
        logic o;
        logic e;
        r = 32'd0; o = 1'b0; e = 1'b0;
        case (op)
            5'd0: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            5'd1: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a << sh;
            5'd5: r = $signed(a) >>> sh;
            5'd6: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r = p[31:0];
                o = (p != $signed({{32{r[31]}}, r}));
            end
            5'd7: begin
                if (b == 32'd0) begin
                    e = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = 32'h8000_0000; o = 1'b1;
                end else begin
                    r = $signed(a) / $signed(b);
                end
            end
            default: e = 1'b1;
        endcase
        model = mk(r, o, e, a != b, $signed(a) < $signed(b));
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                        input logic [4:0] sh, input exp_t e);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_i("send_ready", int'(in_ready), 1);
        data_operandA = a; data_operandB = b; ctrl_ALUopcode = op; ctrl_shiftamt = sh;
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    // Wait for out_valid, compare against the scoreboard, optionally backpressure, release
    task automatic collect(input string tag, input int exp_lat, input int hold);
        int   lat = 0;
        int   busy_ok = 1;
        exp_t e;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) busy_ok = 0;
            @(posedge clk); #1;
            lat++;
        end
        check_i({tag, "_latency"}, lat, exp_lat);
        check_i({tag, "_in_ready_low"}, busy_ok, 1);
        if (sb.size() == 0) begin
            check_i({tag, "_sb_empty"}, 0, 1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check_v({tag, "_outputs"},
                {data_result, overflow, exception, isNotEqual, isLessThan}, e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            data_operandA = 32'h1357_9BDF; data_operandB = 32'h2468_ACE0;
            ctrl_ALUopcode = 5'd0; in_valid = 1'b1;
            @(posedge clk); #1;
            check_v({tag, "_hold_stable"},
                    {data_result, overflow, exception, isNotEqual, isLessThan}, e);
            check_i({tag, "_hold_handshake"}, int'({out_valid, in_ready}), 2);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check_i({tag, "_release"}, int'({out_valid, in_ready}), 1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [4:0]  rop, rsh;
        int          seen;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        data_operandA = 32'd0; data_operandB = 32'd0; ctrl_ALUopcode = 5'd0; ctrl_shiftamt = 5'd0;

        // Reset held while an ADD is offered
        @(negedge clk);
        data_operandA = 32'd5; data_operandB = 32'd9; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_i("reset_handshake", int'({out_valid, in_ready}), 1);
        check_v("reset_outputs", {data_result, overflow, exception, isNotEqual, isLessThan}, 36'd0);
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;

        send(32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 5'd0, mk(32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0));
        collect("add_ovf", 0, 0);
        send(32'h8000_0000, 32'h0000_0000, 5'd5, 5'd4, mk(32'hF800_0000, 1'b0, 1'b0, 1'b1, 1'b1));
        collect("sra4", 0, 0);
        send(32'h8000_0000, 32'h0000_0001, 5'd1, 5'd0, mk(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1));
        collect("sub_ovf", 0, 0);
        send(32'h0000_0001, 32'h0000_0000, 5'd4, 5'd31, mk(32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0));
        collect("sll31", 0, 0);
        send(32'h0000_ABCD, 32'h0000_ABCD, 5'd4, 5'd0, mk(32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 1'b0));
        collect("sll0", 0, 0);
        send(32'h0000_0007, 32'hFFFF_FFFA, 5'd6, 5'd0, mk(32'hFFFF_FFD6, 1'b0, 1'b0, 1'b1, 1'b0));
        collect("mul_7x-6", 32, 0);
        send(32'h0001_0000, 32'h0001_0000, 5'd6, 5'd0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0));
        collect("mul_ovf", 32, 0);
        send(32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 5'd0, mk(32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1));
        collect("mul_min", 32, 0);
        send(32'hFFFF_FFF9, 32'h0000_0002, 5'd7, 5'd0, mk(32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1, 1'b1));
        collect("div_-7/2", 32, 0);
        send(32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 5'd0, mk(32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1));
        collect("div_min", 32, 0);
        send(32'h0000_0005, 32'h0000_0000, 5'd7, 5'd0, mk(32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0));
        collect("div_zero", 0, 0);
        send(32'h0000_0003, 32'h0000_0003, 5'd9, 5'd0, mk(32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0));
        collect("illegal", 0, 0);

        // Backpressure, then an immediate follow-on request
        send(32'hF0F0_F0F0, 32'hFF00_FF00, 5'd2, 5'd0, mk(32'hF000_F000, 1'b0, 1'b0, 1'b1, 1'b1));
        collect("and_bp", 0, 5);
        send(32'h0000_000F, 32'h0000_00F0, 5'd3, 5'd0, mk(32'h0000_00FF, 1'b0, 1'b0, 1'b1, 1'b1));
        collect("or_next", 0, 0);

        // Reset during MUL iteration 10 abandons the operation
        send(32'h0000_0123, 32'h0000_0456, 5'd6, 5'd0, mk(32'h0004_EDC2, 1'b0, 1'b0, 1'b1, 1'b1));
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_i("mid_reset_handshake", int'({out_valid, in_ready}), 1);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1;
        end
        check_i("mid_reset_no_result", seen, 0);
        send(32'd2, 32'd3, 5'd0, 5'd0, mk(32'd5, 1'b0, 1'b0, 1'b1, 1'b1));
        collect("add_after_reset", 0, 0);

        // Random operations against the reference model
        for (int i = 0; i < 10; i++) begin
            ra  = $urandom;
            rb  = (i % 3 == 0) ? (32'($urandom_range(0, 20)) - 32'd10) : $urandom;
            rop = 5'($urandom_range(0, 7));
            rsh = 5'($urandom_range(0, 31));
            send(ra, rb, rop, rsh, model(ra, rb, rop, rsh));
            collect("random", (rop == 5'd6 || (rop == 5'd7 && rb != 32'd0)) ? 32 : 0, 0);
        end

        check_i("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
